// File: rtl/imem_loader_pkg.sv
// Shared CPU definitions: PC reset address and the
// program-loader state encoding.
package imem_loader_pkg;

    localparam logic [15:0] PC_RESET_ADDR = 16'd10;
    localparam int          LD_MAX_WORDS  = 64;

    typedef enum logic [2:0] {
        CNT_HI,
        CNT_LO,
        DATA_HI,
        DATA_LO,
        CHK,
        DONE,
        ERR
    } ld_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port
// of the program loader.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [15:0] im_addr;
    logic [15:0] im_wdata;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output im_we,
        output im_addr,
        output im_wdata
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  im_we,
        input  im_addr,
        input  im_wdata
    );

endinterface

// File: rtl/imem_loader.sv
// Program loader: pairs stream bytes into big-endian words,
// writes them to instruction memory and checks an XOR checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = PC_RESET_ADDR,
    parameter int          MAX_WORDS = LD_MAX_WORDS
) (
    input  logic          Clock,
    input  logic          Reset,
    imem_loader_if.master bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          error,
    output logic [15:0]   words_loaded
);

    ld_state_t   state;
    ld_state_t   state_nx;
    logic [15:0] count;
    logic [15:0] count_in;
    logic [15:0] wl_nx;
    logic [7:0]  hi_byte;
    logic [7:0]  xor_acc;
    logic        accept;
    logic        too_big;
    logic        last_word;

    assign bus.in_ready = (state != DONE) && (state != ERR);
    assign accept       = bus.in_valid && bus.in_ready;
    assign count_in     = {hi_byte, bus.in_data};
    assign too_big      = count_in > 16'(MAX_WORDS);
    assign wl_nx        = words_loaded + 16'd1;
    assign last_word    = (wl_nx == count);

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= CNT_HI;
        else       state <= state_nx;
    end

    // Next-state decode, advancing only on an accepted byte
    always_comb begin
        state_nx = state;
        if (accept) begin
            unique case (state)
                CNT_HI:  state_nx = CNT_LO;
                CNT_LO: begin
                    if (too_big)
                        state_nx = ERR;
                    else if (count_in == 16'd0)
                        state_nx = CHK;
                    else
                        state_nx = DATA_HI;
                end
                DATA_HI: state_nx = DATA_LO;
                DATA_LO: state_nx = last_word ? CHK : DATA_HI;
                CHK: begin
                    if (bus.in_data == xor_acc)
                        state_nx = DONE;
                    else
                        state_nx = ERR;
                end
                default: state_nx = state;
            endcase
        end
    end

    // Registered status flags, following the state being entered
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            done     <= (state_nx == DONE);
            error    <= (state_nx == ERR);
            cpu_hold <= (state_nx != DONE);
        end
    end

    // Byte capture: high byte, word count and running XOR
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            hi_byte <= 8'd0;
            count   <= 16'd0;
            xor_acc <= 8'd0;
        end else if (accept) begin
            if (state != CHK)
                xor_acc <= xor_acc ^ bus.in_data;
            if (state == CNT_HI || state == DATA_HI)
                hi_byte <= bus.in_data;
            if (state == CNT_LO)
                count <= count_in;
        end
    end

    // Memory write port: one-cycle strobe, address steps after it
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            bus.im_we    <= 1'b0;
            bus.im_addr  <= BASE_ADDR;
            bus.im_wdata <= 16'd0;
            words_loaded <= 16'd0;
        end else begin
            bus.im_we <= 1'b0;
            if (bus.im_we)
                bus.im_addr <= bus.im_addr + 16'd2;
            if (accept && state == DATA_LO) begin
                bus.im_we    <= 1'b1;
                bus.im_wdata <= {hi_byte, bus.in_data};
                words_loaded <= wl_nx;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load, checksum, overflow,
// empty image, throttled stream and mid-load reset.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int total = 0;
    int bad   = 0;

    logic [15:0] wa[$];
    logic [15:0] wd[$];

    imem_loader_if bus();

    imem_loader dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 Clock = ~Clock;

    // Record every write strobe seen mid-cycle
    always @(negedge Clock) begin
        if (!Reset && bus.im_we) begin
            wa.push_back(bus.im_addr);
            wd.push_back(bus.im_wdata);
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    task automatic do_reset();
        Reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        repeat (2) @(posedge Clock);
        #2 Reset = 1'b0;
        @(posedge Clock);
        #1;
        wa.delete();
        wd.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int tries;
        if (gaps && $urandom_range(0, 1) == 1) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            repeat ($urandom_range(1, 3)) begin
                @(posedge Clock);
                #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        tries = 0;
        while (bus.in_ready !== 1'b1 && tries < 20) begin
            @(posedge Clock);
            #1;
            tries++;
        end
        if (tries >= 20) begin
            total++;
            bad++;
            $display("FAIL accept_timeout byte=%h in_ready=%b want 1",
                     b, bus.in_ready);
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic send_stream(input logic [7:0] s[$], input bit gaps);
        foreach (s[i]) send_byte(s[i], gaps);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_in_ready got=%b want=1", bus.in_ready);
        end
        total++;
        if (cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL rst_cpu_hold got=%b want=1", cpu_hold);
        end
        total++;
        if (bus.im_we !== 1'b0) begin
            bad++;
            $display("FAIL rst_im_we got=%b want=0", bus.im_we);
        end
        total++;
        if (bus.im_addr !== 16'd10) begin
            bad++;
            $display("FAIL rst_im_addr got=%0d want=10", bus.im_addr);
        end
        total++;
        if (bus.im_wdata !== 16'h0000) begin
            bad++;
            $display("FAIL rst_im_wdata got=%h want=0000", bus.im_wdata);
        end
        total++;
        if (done !== 1'b0 || error !== 1'b0) begin
            bad++;
            $display("FAIL rst_flags got done=%b error=%b want 0 0",
                     done, error);
        end
        total++;
        if (words_loaded !== 16'd0) begin
            bad++;
            $display("FAIL rst_words got=%0d want=0", words_loaded);
        end
    endtask

    // Running XOR of 00 02 12 34 AB CD is 0x42
    task automatic test_load(input bit gaps);
        logic [7:0] s[$];
        do_reset();
        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        send_stream(s, gaps);
        total++;
        if (done !== 1'b0 || cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL load_pre_chk g=%0d done=%b hold=%b want 0 1",
                     gaps, done, cpu_hold);
        end
        send_byte(8'h42, gaps);
        bus.in_valid = 1'b0;
        total++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0) begin
            bad++;
            $display("FAIL load_done g=%0d done=%b hold=%b err=%b want 1 0 0",
                     gaps, done, cpu_hold, error);
        end
        total++;
        if (words_loaded !== 16'd2) begin
            bad++;
            $display("FAIL load_words g=%0d got=%0d want=2",
                     gaps, words_loaded);
        end
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL load_ready g=%0d got=%b want=0", gaps, bus.in_ready);
        end
        total++;
        if (bus.im_addr !== 16'd14) begin
            bad++;
            $display("FAIL load_addr g=%0d got=%0d want=14", gaps, bus.im_addr);
        end
        total++;
        if (wa.size() != 2) begin
            bad++;
            $display("FAIL load_nwr g=%0d got=%0d want=2", gaps, wa.size());
        end else begin
            if (wa[0] !== 16'd10 || wd[0] !== 16'h1234) begin
                bad++;
                $display("FAIL load_wr0 g=%0d got=(%0d,%h) want=(10,1234)",
                         gaps, wa[0], wd[0]);
            end
            total++;
            if (wa[1] !== 16'd12 || wd[1] !== 16'hABCD) begin
                bad++;
                $display("FAIL load_wr1 g=%0d got=(%0d,%h) want=(12,abcd)",
                         gaps, wa[1], wd[1]);
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        repeat (3) begin
            @(posedge Clock);
            #1;
        end
        bus.in_valid = 1'b0;
        total++;
        if (done !== 1'b1 || wa.size() != 2) begin
            bad++;
            $display("FAIL load_terminal g=%0d done=%b nwr=%0d want 1 2",
                     gaps, done, wa.size());
        end
    endtask

    task automatic test_bad_chk();
        logic [7:0] s[$];
        do_reset();
        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        send_stream(s, 1'b0);
        bus.in_valid = 1'b0;
        total++;
        if (error !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL badchk_flags err=%b done=%b want 1 0", error, done);
        end
        total++;
        if (cpu_hold !== 1'b1 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL badchk_hold hold=%b ready=%b want 1 0",
                     cpu_hold, bus.in_ready);
        end
        total++;
        if (wa.size() != 2 || words_loaded !== 16'd2) begin
            bad++;
            $display("FAIL badchk_writes nwr=%0d words=%0d want 2 2",
                     wa.size(), words_loaded);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        send_byte(8'h00, 1'b0);
        send_byte(8'h41, 1'b0);
        bus.in_valid = 1'b0;
        total++;
        if (error !== 1'b1 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL ovf_err err=%b ready=%b want 1 0",
                     error, bus.in_ready);
        end
        repeat (3) @(posedge Clock);
        #1;
        total++;
        if (wa.size() != 0 || words_loaded !== 16'd0) begin
            bad++;
            $display("FAIL ovf_nowrite nwr=%0d words=%0d want 0 0",
                     wa.size(), words_loaded);
        end
        total++;
        if (done !== 1'b0 || cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL ovf_hold done=%b hold=%b want 0 1", done, cpu_hold);
        end
    endtask

    task automatic test_max_count();
        do_reset();
        send_byte(8'h00, 1'b0);
        send_byte(8'h40, 1'b0);
        bus.in_valid = 1'b0;
        total++;
        if (error !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL max64 err=%b ready=%b want 0 1",
                     error, bus.in_ready);
        end
    endtask

    task automatic test_zero();
        logic [7:0] s[$];
        do_reset();
        s = '{8'h00, 8'h00, 8'h00};
        send_stream(s, 1'b0);
        bus.in_valid = 1'b0;
        total++;
        if (done !== 1'b1 || error !== 1'b0) begin
            bad++;
            $display("FAIL zero_done done=%b err=%b want 1 0", done, error);
        end
        total++;
        if (words_loaded !== 16'd0 || wa.size() != 0) begin
            bad++;
            $display("FAIL zero_writes words=%0d nwr=%0d want 0 0",
                     words_loaded, wa.size());
        end
        total++;
        if (bus.im_addr !== 16'd10) begin
            bad++;
            $display("FAIL zero_addr got=%0d want=10", bus.im_addr);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s[$];
        do_reset();
        s = '{8'h00, 8'h02, 8'h12, 8'h34};
        send_stream(s, 1'b0);
        total++;
        if (bus.im_we !== 1'b1) begin
            bad++;
            $display("FAIL mid_we_pre got=%b want=1", bus.im_we);
        end
        Reset = 1'b1;
        #1;
        total++;
        if (bus.im_we !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_async we=%b ready=%b want 0 1",
                     bus.im_we, bus.in_ready);
        end
        do_reset();
        s = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_stream(s, 1'b0);
        bus.in_valid = 1'b0;
        total++;
        if (wa.size() == 0 || wa[0] !== 16'd10 || wd[0] !== 16'h1234) begin
            bad++;
            $display("FAIL mid_first_wr nwr=%0d want first (10,1234)",
                     wa.size());
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL mid_done got=%b want=1", done);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        test_reset();
        test_load(1'b0);
        test_bad_chk();
        test_overflow();
        test_max_count();
        test_zero();
        test_load(1'b1);
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
